csr_regfile: RTL and testbench
==============================

// Module: csr_regfile
// PURPOSE
//  Machine-mode CSR storage consumed by the exec-stage CSR unit via csrfile_req/csrfile_resp.
//  Decodes 12-bit address, returns old value and existence combinationally, commits RW/RS/RC at clk edge.
//  Also owns trap entry/mret state updates and free-running counters; exports mtvec/mepc/MIE to frontend/trap logic.
// PARAMETERS
//  HART_ID   0            value returned by mhartid (0xF14)
//  MISA_VAL  32'h40000100 value returned by misa (0x301), RV32I
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous active-high reset
//  csrfile_req   decoupled.in  -  data.a[11:0] addr, data.d[31:0] operand, data.t[1:0] op (01 RW,10 RS,11 RC)
//  csrfile_resp  out  csr_resp  exists (addr implemented), d[31:0] pre-op value of addressed CSR
//  retire        in   1      one instruction retired this cycle (minstret increment)
//  trap_valid    in   1      take trap this cycle
//  trap_cause    in   32     mcause value to record
//  trap_epc      in   32     faulting PC -> mepc
//  trap_tval     in   32     -> mtval
//  mret          in   1      return from trap this cycle
//  mtvec_o       out  32     current mtvec
//  mepc_o        out  32     current mepc
//  mie_o         out  1      mstatus.MIE
// BEHAVIOUR
//  - Implemented: mvendorid F11, marchid F12, mimpid F13 (all 0), mhartid F14, mstatus 300, misa 301,
//    mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344 (reads 0). Others: exists=0, d=0.
//  - Read path purely combinational from data.a; zero-cycle latency; resp valid whenever req data stable.
//  - csrfile_req.ready = !trap_valid && !mret. Fire = valid && ready; writes land at that clk edge.
//  - New value: RW d; RS old|d; RC old&~d. t=00 or exists=0: no write. RS/RC with d==0: no write.
//  - Writes to read-only CSRs (a[11:10]==11, misa, mip) silently dropped; resp still returns old value.
//  - WARL masks: mstatus only MIE[3], MPIE[7] writable, MPP[12:11] reads 2'b11; mtvec[1:0] forced 00;
//    mepc[1:0] forced 00; mie only bits 3,7,11 writable.
//  - Trap (priority over mret and req): mepc<=trap_epc&~3, mcause<=trap_cause, mtval<=trap_tval,
//    MPIE<=MIE, MIE<=0. mret (no trap): MIE<=MPIE, MPIE<=1.
//  - Reset: mstatus MIE=0 MPIE=0; mtvec, mscratch, mepc, mcause, mtval, mie=0; counters=0; outputs follow.
//  - Outputs mtvec_o/mepc_o/mie_o registered-state views, change the cycle after the update edge.
//  - rst mid-transaction: reset wins, pending fire discarded, no partial write.
// CONFIGURATION
//  CSR_COUNTERS_EN defined: adds 64-bit mcycle (B00/B80), minstret (B02/B82), RO aliases cycle C00/C80,
//    instret C02/C82. mcycle +1 every cycle; minstret +1 when retire. Software write to a half replaces
//    that half and suppresses that cycle's increment; carry wraps 2^64-1 -> 0. Low->high carry same edge.
//  Undefined: all counter addresses report exists=0, d=0; retire ignored (lint-unused sink).
// TESTING
//  - Reset, read 0x305 -> exists=1, d=0; read 0x7C0 -> exists=0, d=0.
//  - RW 0x340 d=DEADBEEF, then RS d=0000_0010, then RC d=DEAD0000 -> reads DEADBEEF, DEADBEFF, 0000BEFF.
//  - RW 0x305 d=8000_0007 -> next read 8000_0004, mtvec_o=8000_0004; RW 0xF14 d=0 -> no change, d=HART_ID.
//  - MIE=1 then trap_valid cause=2 epc=0000_1003 tval=5 with req valid -> req.ready=0, mepc=0000_1000,
//    mcause=2, mtval=5, MIE=0 MPIE=1; next mret -> MIE=1, MPIE=1.
//  - COUNTERS_EN: write mcycle lo=FFFF_FFFF, hi=FFFF_FFFF -> wraps to 0 then counts 1,2; instret counts only
//    retire cycles; C00 read ok, RW C00 d=0 leaves count running. Without macro: B00 exists=0.

Source files
------------

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage behind the exec-stage CSR unit.
// Reads are combinational. RW/RS/RC writes commit on the clock edge.
// The block also updates trap/mret state and exports mtvec/mepc/MIE.
// Optional feature macro: CSR_COUNTERS_EN adds mcycle/minstret and the cycle/instret aliases.

package csr_regfile_pkg;
    typedef struct packed {
        logic [11:0] a;    // CSR address
        logic [31:0] d;    // operand
        logic [1:0]  t;    // 01 RW, 10 RS, 11 RC, 00 read only
    } csr_req_t;

    typedef struct packed {
        logic        exists;
        logic [31:0] d;
    } csr_resp_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;
endpackage

module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrfile_req_valid,
    output logic        csrfile_req_ready,
    input  csr_req_t    csrfile_req_data,
    output csr_resp_t   csrfile_resp,
    input  logic        retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);
    logic        mstatus_mie, mstatus_mpie;
    logic [31:0] mie_en_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [31:0] mstatus_rd;
    logic        rd_exists;
    logic [31:0] rd_val, new_val;
    logic        read_only, wr_en;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q;
`else
    logic        unused_retire;
    assign unused_retire = retire;
`endif

    // MPP is hardwired to machine mode; only MIE and MPIE hold state.
    assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};

    // Trap and mret own the cycle; the CSR port stalls while either is active.
    assign csrfile_req_ready = !trap_valid && !mret;

    // Address decode and the old-value read mux.
    always_comb begin
        rd_exists = 1'b1;
        rd_val    = 32'd0;
        case (csrfile_req_data.a)
            12'hF11, 12'hF12, 12'hF13: rd_val = 32'd0;
            12'hF14: rd_val = HART_ID;
            12'h300: rd_val = mstatus_rd;
            12'h301: rd_val = MISA_VAL;
            12'h304: rd_val = mie_en_q;
            12'h305: rd_val = mtvec_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344: rd_val = 32'd0;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: rd_val = mcycle_q[31:0];
            12'hB80, 12'hC80: rd_val = mcycle_q[63:32];
            12'hB02, 12'hC02: rd_val = minstret_q[31:0];
            12'hB82, 12'hC82: rd_val = minstret_q[63:32];
`endif
            default: rd_exists = 1'b0;
        endcase
    end

    assign csrfile_resp.exists = rd_exists;
    assign csrfile_resp.d      = rd_val;

    // Read-modify-write value for the requested op.
    always_comb begin
        new_val = rd_val;
        case (csrfile_req_data.t)
            OP_RW:   new_val = csrfile_req_data.d;
            OP_RS:   new_val = rd_val | csrfile_req_data.d;
            OP_RC:   new_val = rd_val & ~csrfile_req_data.d;
            default: new_val = rd_val;
        endcase
    end

    // The 0xC../0xF.. space is read-only by encoding. misa and mip are read-only as well.
    assign read_only = (csrfile_req_data.a[11:10] == 2'b11) ||
                       (csrfile_req_data.a == 12'h301) || (csrfile_req_data.a == 12'h344);

    // RS/RC with a zero mask are pure reads and must not write.
    assign wr_en = csrfile_req_valid && csrfile_req_ready && (csrfile_req_data.t != 2'b00) &&
                   rd_exists && !read_only &&
                   ((csrfile_req_data.t == OP_RW) || (csrfile_req_data.d != 32'd0));

    // CSR state update. Priority order: trap, then mret, then software write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_en_q     <= 32'd0;
            mtvec_q      <= 32'd0;
            mscratch_q   <= 32'd0;
            mepc_q       <= 32'd0;
            mcause_q     <= 32'd0;
            mtval_q      <= 32'd0;
        end else if (trap_valid) begin
            mepc_q       <= trap_epc & ~32'd3;
            mcause_q     <= trap_cause;
            mtval_q      <= trap_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_en) begin
            case (csrfile_req_data.a)
                12'h300: begin
                    mstatus_mie  <= new_val[3];
                    mstatus_mpie <= new_val[7];
                end
                12'h304: mie_en_q   <= new_val & 32'h0000_0888;
                12'h305: mtvec_q    <= new_val & ~32'd3;
                12'h340: mscratch_q <= new_val;
                12'h341: mepc_q     <= new_val & ~32'd3;
                12'h342: mcause_q   <= new_val;
                12'h343: mtval_q    <= new_val;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // Free-running counters. A software write to either half replaces it and skips that increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            if (wr_en && csrfile_req_data.a == 12'hB00)
                mcycle_q[31:0] <= new_val;
            else if (wr_en && csrfile_req_data.a == 12'hB80)
                mcycle_q[63:32] <= new_val;
            else
                mcycle_q <= mcycle_q + 64'd1;

            if (wr_en && csrfile_req_data.a == 12'hB02)
                minstret_q[31:0] <= new_val;
            else if (wr_en && csrfile_req_data.a == 12'hB82)
                minstret_q[63:32] <= new_val;
            else if (retire)
                minstret_q <= minstret_q + 64'd1;
        end
    end
`endif

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mstatus_mie;
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: the directed table checks the documented CSR behaviour.
// Hand sequences cover trap/mret, the counters and reset during a request.
// A random phase is compared against a behavioural CSR model.
module tb_csr_regfile;
    import csr_regfile_pkg::*;

    localparam logic [31:0] HART = 32'h0000_0005;
    localparam logic [31:0] MISA = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    csr_req_t    req;
    csr_resp_t   resp;
    logic        retire, trap_valid, mret;
    logic [31:0] trap_cause, trap_epc, trap_tval;
    logic [31:0] mtvec_o, mepc_o;
    logic        mie_o;

    int n_vec = 0;
    int n_err = 0;

    csr_regfile #(.HART_ID(HART), .MISA_VAL(MISA)) dut (
        .clk(clk), .rst(rst),
        .csrfile_req_valid(req_valid), .csrfile_req_ready(req_ready),
        .csrfile_req_data(req), .csrfile_resp(resp),
        .retire(retire), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_epc(trap_epc), .trap_tval(trap_tval), .mret(mret),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_scratch, m_tvec, m_epc, m_cause, m_tval, m_ie;
    bit          m_mie, m_mpie;
    bit   [63:0] m_cyc, m_ins;

    function automatic void model_reset();
        m_scratch = 0; m_tvec = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_ie = 0;
        m_mie = 0; m_mpie = 0; m_cyc = 0; m_ins = 0;
    endfunction

    function automatic void model_read(input logic [11:0] a, output bit ex, output logic [31:0] v);
        ex = 1; v = 0;
        case (a)
            12'hF11, 12'hF12, 12'hF13, 12'h344: v = 0;
            12'hF14: v = HART;
            12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 0) | (m_mie ? 32'h8 : 0);
            12'h301: v = MISA;
            12'h304: v = m_ie;
            12'h305: v = m_tvec;
            12'h340: v = m_scratch;
            12'h341: v = m_epc;
            12'h342: v = m_cause;
            12'h343: v = m_tval;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_ins[31:0];
            12'hB82, 12'hC82: v = m_ins[63:32];
`endif
            default: ex = 0;
        endcase
    endfunction

    // Advance the model across one clock edge using the currently driven inputs.
    function automatic void model_step();
        bit ex, cyc_wr, ins_wr;
        logic [31:0] old, nv;
        cyc_wr = 0; ins_wr = 0;
        if (rst) begin
            model_reset();
            return;
        end
        model_read(req.a, ex, old);
        if (trap_valid) begin
            m_epc = {trap_epc[31:2], 2'b00}; m_cause = trap_cause; m_tval = trap_tval;
            m_mpie = m_mie; m_mie = 0;
        end else if (mret) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (req_valid && req.t != 0 && ex &&
                     !(req.a[11:10] == 2'b11 || req.a == 12'h301 || req.a == 12'h344) &&
                     !(req.t != 2'b01 && req.d == 0)) begin
            nv = (req.t == 2'b01) ? req.d : (req.t == 2'b10) ? (old | req.d) : (old & ~req.d);
            case (req.a)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_ie = nv & 32'h888;
                12'h305: m_tvec = {nv[31:2], 2'b00};
                12'h340: m_scratch = nv;
                12'h341: m_epc = {nv[31:2], 2'b00};
                12'h342: m_cause = nv;
                12'h343: m_tval = nv;
                12'hB00: begin m_cyc = {m_cyc[63:32], nv}; cyc_wr = 1; end
                12'hB80: begin m_cyc = {nv, m_cyc[31:0]}; cyc_wr = 1; end
                12'hB02: begin m_ins = {m_ins[63:32], nv}; ins_wr = 1; end
                12'hB82: begin m_ins = {nv, m_ins[31:0]}; ins_wr = 1; end
                default: ;
            endcase
        end
        if (!cyc_wr) m_cyc = m_cyc + 1;
        if (!ins_wr && retire) m_ins = m_ins + 1;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] a, input logic [1:0] t, input logic [31:0] d);
        req_valid = v; req.a = a; req.t = t; req.d = d;
    endtask

    // One cycle: check the combinational response against the model, then cross the edge and check the registered views.
    task automatic tick();
        bit ex; logic [31:0] v;
        #1;
        model_read(req.a, ex, v);
        chk("resp.exists", {31'd0, resp.exists}, {31'd0, ex});
        chk("resp.d", resp.d, v);
        chk("req_ready", {31'd0, req_ready}, {31'd0, !trap_valid && !mret});
        model_step();
        @(posedge clk); #1;
        chk("mtvec_o", mtvec_o, m_tvec);
        chk("mepc_o", mepc_o, m_epc);
        chk("mie_o", {31'd0, mie_o}, {31'd0, m_mie});
    endtask

    // Combinational read within the current cycle, with no request fired.
    task automatic peek(input string name, input logic [11:0] a, input bit ex, input logic [31:0] v);
        drive(1'b0, a, 2'b00, 32'd0);
        #1;
        chk({name, ".exists"}, {31'd0, resp.exists}, {31'd0, ex});
        chk({name, ".d"}, resp.d, v);
    endtask

    typedef struct {
        logic [11:0] a;
        logic [1:0]  t;
        logic [31:0] d;
        bit          ex;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl[$];

    logic [11:0] addrs[$] = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304,
                             12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                             12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                             12'h7C0, 12'h345};

    initial begin
        rst = 1; retire = 0; trap_valid = 0; mret = 0;
        trap_cause = 0; trap_epc = 0; trap_tval = 0;
        drive(1'b0, 12'h000, 2'b00, 32'd0);
        @(posedge clk); #1;
        model_reset();
        tick();
        rst = 0;
        chk("reset mtvec_o", mtvec_o, 32'd0);
        chk("reset mepc_o", mepc_o, 32'd0);
        chk("reset mie_o", {31'd0, mie_o}, 32'd0);

        tbl.push_back('{12'h305, 2'b00, 32'h0,        1, 32'h0});
        tbl.push_back('{12'h7C0, 2'b00, 32'h0,        0, 32'h0});
        tbl.push_back('{12'h340, 2'b01, 32'hDEADBEEF, 1, 32'h0});
        tbl.push_back('{12'h340, 2'b10, 32'h00000010, 1, 32'hDEADBEEF});
        tbl.push_back('{12'h340, 2'b11, 32'hDEAD0000, 1, 32'hDEADBEFF});
        tbl.push_back('{12'h340, 2'b00, 32'h0,        1, 32'h0000BEFF});
        tbl.push_back('{12'h305, 2'b01, 32'h80000007, 1, 32'h0});
        tbl.push_back('{12'h305, 2'b00, 32'h0,        1, 32'h80000004});
        tbl.push_back('{12'hF14, 2'b01, 32'h0,        1, HART});
        tbl.push_back('{12'hF14, 2'b00, 32'h0,        1, HART});
        tbl.push_back('{12'h301, 2'b01, 32'h0,        1, MISA});
        tbl.push_back('{12'h301, 2'b00, 32'h0,        1, MISA});
        tbl.push_back('{12'h300, 2'b01, 32'hFFFFFFFF, 1, 32'h00001800});
        tbl.push_back('{12'h300, 2'b00, 32'h0,        1, 32'h00001888});
        tbl.push_back('{12'h300, 2'b11, 32'h00000008, 1, 32'h00001888});
        tbl.push_back('{12'h300, 2'b00, 32'h0,        1, 32'h00001880});
        tbl.push_back('{12'h304, 2'b01, 32'hFFFFFFFF, 1, 32'h0});
        tbl.push_back('{12'h304, 2'b00, 32'h0,        1, 32'h00000888});
        tbl.push_back('{12'h341, 2'b01, 32'hFFFFFFFF, 1, 32'h0});
        tbl.push_back('{12'h341, 2'b00, 32'h0,        1, 32'hFFFFFFFC});
        tbl.push_back('{12'h344, 2'b01, 32'hFFFFFFFF, 1, 32'h0});
        tbl.push_back('{12'h344, 2'b00, 32'h0,        1, 32'h0});
        tbl.push_back('{12'hF11, 2'b00, 32'h0,        1, 32'h0});
        tbl.push_back('{12'h340, 2'b10, 32'h0,        1, 32'h0000BEFF});
        tbl.push_back('{12'h340, 2'b00, 32'h0,        1, 32'h0000BEFF});
        tbl.push_back('{12'h343, 2'b01, 32'h00000077, 1, 32'h0});
        tbl.push_back('{12'h343, 2'b00, 32'h0,        1, 32'h00000077});

        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].a, tbl[i].t, tbl[i].d);
            #1;
            chk($sformatf("tbl[%0d].exists", i), {31'd0, resp.exists}, {31'd0, tbl[i].ex});
            chk($sformatf("tbl[%0d].d", i), resp.d, tbl[i].rd);
            tick();
        end
        chk("mtvec_o after RW", mtvec_o, 32'h80000004);

        // Trap entry while a request is pending, then mret.
        drive(1'b1, 12'h300, 2'b01, 32'h8);
        tick();
        chk("mie_o set", {31'd0, mie_o}, 32'd1);
        drive(1'b1, 12'h340, 2'b01, 32'h1234);
        trap_valid = 1; trap_cause = 2; trap_epc = 32'h1003; trap_tval = 5;
        #1;
        chk("ready during trap", {31'd0, req_ready}, 32'd0);
        tick();
        trap_valid = 0;
        chk("trap mepc_o", mepc_o, 32'h1000);
        chk("trap mie_o", {31'd0, mie_o}, 32'd0);
        peek("trap mcause", 12'h342, 1, 32'h2);
        peek("trap mtval", 12'h343, 1, 32'h5);
        peek("trap mstatus", 12'h300, 1, 32'h1880);
        peek("trap mscratch kept", 12'h340, 1, 32'h0000BEFF);
        mret = 1;
        tick();
        mret = 0;
        chk("mret mie_o", {31'd0, mie_o}, 32'd1);
        peek("mret mstatus", 12'h300, 1, 32'h1888);

`ifdef CSR_COUNTERS_EN
        drive(1'b1, 12'hB00, 2'b01, 32'hFFFFFFFF); tick();
        drive(1'b1, 12'hB80, 2'b01, 32'hFFFFFFFF); tick();
        peek("mcycle lo max", 12'hB00, 1, 32'hFFFFFFFF);
        peek("mcycle hi max", 12'hB80, 1, 32'hFFFFFFFF);
        drive(1'b0, 12'h000, 2'b00, 32'd0); tick();
        peek("mcycle wrap lo", 12'hB00, 1, 32'h0);
        peek("mcycle wrap hi", 12'hB80, 1, 32'h0);
        peek("cycle alias lo", 12'hC00, 1, 32'h0);
        peek("cycle alias hi", 12'hC80, 1, 32'h0);
        tick();
        peek("mcycle 1", 12'hB00, 1, 32'h1);
        drive(1'b1, 12'hC00, 2'b01, 32'h0); tick();
        peek("cycle RO write", 12'hC00, 1, 32'h2);
        drive(1'b1, 12'hB00, 2'b01, 32'hFFFFFFFF); tick();
        drive(1'b1, 12'hB80, 2'b01, 32'h0); tick();
        drive(1'b0, 12'h000, 2'b00, 32'd0); tick();
        peek("carry hi", 12'hB80, 1, 32'h1);
        peek("carry lo", 12'hB00, 1, 32'h0);
        drive(1'b1, 12'hB02, 2'b01, 32'h0); tick();
        drive(1'b1, 12'hB82, 2'b01, 32'h0); tick();
        drive(1'b0, 12'h000, 2'b00, 32'd0);
        for (int k = 0; k < 5; k++) begin
            retire = (k == 0 || k == 2 || k == 3);
            tick();
        end
        retire = 0;
        peek("instret lo", 12'hC02, 1, 32'h3);
        peek("instret hi", 12'hC82, 1, 32'h0);
`else
        peek("mcycle absent", 12'hB00, 0, 32'h0);
        peek("cycle absent", 12'hC00, 0, 32'h0);
        peek("minstret absent", 12'hB02, 0, 32'h0);
`endif

        // Reset arriving with a write pending discards the write.
        drive(1'b1, 12'h340, 2'b01, 32'h12345678);
        rst = 1;
        tick();
        rst = 0;
        peek("rst discards write", 12'h340, 1, 32'h0);
        chk("rst mtvec_o", mtvec_o, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, addrs[$urandom_range(0, addrs.size() - 1)],
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            trap_valid = ($urandom_range(0, 11) == 0);
            mret       = ($urandom_range(0, 11) == 0);
            retire     = $urandom_range(0, 1) != 0;
            rst        = ($urandom_range(0, 79) == 0);
            trap_cause = $urandom; trap_epc = $urandom; trap_tval = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
